sts_preamble_inserter: RTL and testbench

- Transmit-side framer for the OFDM baseband path. It is the counterpart of the receiver's STS correlator/accumulator.
- On a frame start it emits the 16-sample short training sequence (STS) STS_REPS times back to back. It then forwards payload I/Q samples from upstream until the frame's last sample.
- Both sides use a valid/ready handshake with a registered output. The block sits between the IFFT/cyclic-prefix stage and the DAC interface.

---
 rtl/ofdm_tx_pkg.sv | 40 ++++
 rtl/sts_rom.sv | 25 ++
 rtl/sts_preamble_inserter.sv | 141 ++++++++++++++
 tb/tb_sts_preamble_inserter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_tx_pkg.sv
// Shared definitions for the OFDM transmit path: sample width, STS length,
// the framer state encoding and the 16-entry short training sequence tables.
package ofdm_tx_pkg;

    localparam int SAMPLE_W = 16;
    localparam int STS_LEN  = 16;
    localparam int IDX_W    = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STS     = 2'd1,
        PAYLOAD = 2'd2
    } txState_t;

    // Short training sequence, real part, Q1.14.
    localparam logic [SAMPLE_W-1:0] STS_R [STS_LEN] = '{
        16'h02F1, 16'hF78E, 16'hFF2C, 16'h0926,
        16'h05E3, 16'h0926, 16'hFF2C, 16'hF78E,
        16'h02F1, 16'h0020, 16'hFAF2, 16'hFF2C,
        16'h0000, 16'hFF2C, 16'hFAF2, 16'h0020
    };

    // Short training sequence, imaginary part, Q1.14.
    localparam logic [SAMPLE_W-1:0] STS_I [STS_LEN] = '{
        16'h02F1, 16'h0020, 16'hFAF2, 16'hFF2C,
        16'h0000, 16'hFF2C, 16'hFAF2, 16'h0020,
        16'h02F1, 16'hF78E, 16'hFF2C, 16'h0926,
        16'h05E3, 16'h0926, 16'hFF2C, 16'hF78E
    };

    // True when the sample being loaded is the final one of the whole preamble.
    function automatic logic isLastStsSample(
        input logic [IDX_W-1:0] sampleIdx,
        input logic [IDX_W-1:0] repCnt,
        input logic [IDX_W-1:0] lastRep
    );
        return (sampleIdx == IDX_W'(STS_LEN - 1)) && (repCnt == lastRep);
    endfunction

endpackage

// File: rtl/sts_rom.sv
// Combinational STS lookup: index -> (real, imaginary). Shared with the
// receiver-side golden model, so it carries no clock or state.
module sts_rom
    import ofdm_tx_pkg::*;
(
    input  logic [IDX_W-1:0]    Idx,
    output logic [SAMPLE_W-1:0] DataR,
    output logic [SAMPLE_W-1:0] DataI
);

    logic [SAMPLE_W-1:0] romR [STS_LEN];
    logic [SAMPLE_W-1:0] romI [STS_LEN];

    // Unroll the package constants into a local table indexed by Idx.
    generate
        for (genvar gi = 0; gi < STS_LEN; gi++) begin : g_rom
            assign romR[gi] = STS_R[gi];
            assign romI[gi] = STS_I[gi];
        end
    endgenerate

    assign DataR = romR[Idx];
    assign DataI = romI[Idx];

endmodule

// File: rtl/sts_preamble_inserter.sv
// Transmit framer: on Start emits STS_REPS copies of the 16-sample short
// training sequence, then forwards payload samples until PayloadLast.
// Output is a single registered valid/ready stage; upstream readiness is
// derived combinationally from whether that stage can load this cycle.
module sts_preamble_inserter
    import ofdm_tx_pkg::*;
#(
    parameter int STS_REPS = 10
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Start,
    output logic                Busy,
    input  logic                PayloadEnable,
    input  logic [SAMPLE_W-1:0] PayloadDataR,
    input  logic [SAMPLE_W-1:0] PayloadDataI,
    input  logic                PayloadLast,
    output logic                PayloadReady,
    output logic                OutEnable,
    output logic [SAMPLE_W-1:0] OutDataR,
    output logic [SAMPLE_W-1:0] OutDataI,
    output logic                OutLast,
    input  logic                OutReady
);

    localparam logic [IDX_W-1:0] LAST_REP = IDX_W'(STS_REPS - 1);

    txState_t            stateReg,     stateNext;
    logic [IDX_W-1:0]    sampleIdxReg, sampleIdxNext;
    logic [IDX_W-1:0]    repCntReg,    repCntNext;
    logic                outEnableReg, outEnableNext;
    logic [SAMPLE_W-1:0] outDataRReg,  outDataRNext;
    logic [SAMPLE_W-1:0] outDataIReg,  outDataINext;
    logic                outLastReg,   outLastNext;

    logic                load;
    logic [SAMPLE_W-1:0] stsR;
    logic [SAMPLE_W-1:0] stsI;

    sts_rom u_sts_rom (
        .Idx   (sampleIdxReg),
        .DataR (stsR),
        .DataI (stsI)
    );

    // The output stage may take a new value when empty or being drained.
    assign load = !outEnableReg || OutReady;

    // Next-state and output-register load selection.
    always_comb begin
        stateNext     = stateReg;
        sampleIdxNext = sampleIdxReg;
        repCntNext    = repCntReg;
        outEnableNext = outEnableReg;
        outDataRNext  = outDataRReg;
        outDataINext  = outDataIReg;
        outLastNext   = outLastReg;

        case (stateReg)
            IDLE: begin
                // Drain whatever is left in the output stage; nothing new to send.
                if (load) begin
                    outEnableNext = 1'b0;
                    outLastNext   = 1'b0;
                end
                if (Start) begin
                    stateNext     = STS;
                    sampleIdxNext = '0;
                    repCntNext    = '0;
                end
            end

            STS: begin
                if (load) begin
                    outEnableNext = 1'b1;
                    outDataRNext  = stsR;
                    outDataINext  = stsI;
                    outLastNext   = 1'b0;
                    sampleIdxNext = sampleIdxReg + 1'b1;
                    if (sampleIdxReg == IDX_W'(STS_LEN - 1)) begin
                        repCntNext = repCntReg + 1'b1;
                    end
                    if (isLastStsSample(sampleIdxReg, repCntReg, LAST_REP)) begin
                        stateNext = PAYLOAD;
                    end
                end
            end

            PAYLOAD: begin
                if (load) begin
                    if (PayloadEnable) begin
                        outEnableNext = 1'b1;
                        outDataRNext  = PayloadDataR;
                        outDataINext  = PayloadDataI;
                        outLastNext   = PayloadLast;
                        if (PayloadLast) begin
                            stateNext = IDLE;
                        end
                    end else begin
                        // Upstream gap: the output stage simply goes empty.
                        outEnableNext = 1'b0;
                        outLastNext   = 1'b0;
                    end
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State, counters and output register; reset clears everything.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            stateReg     <= IDLE;
            sampleIdxReg <= '0;
            repCntReg    <= '0;
            outEnableReg <= 1'b0;
            outDataRReg  <= '0;
            outDataIReg  <= '0;
            outLastReg   <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            sampleIdxReg <= sampleIdxNext;
            repCntReg    <= repCntNext;
            outEnableReg <= outEnableNext;
            outDataRReg  <= outDataRNext;
            outDataIReg  <= outDataINext;
            outLastReg   <= outLastNext;
        end
    end

    assign PayloadReady = (stateReg == PAYLOAD) && load;
    assign Busy         = (stateReg != IDLE) || outEnableReg;
    assign OutEnable    = outEnableReg;
    assign OutDataR     = outDataRReg;
    assign OutDataI     = outDataIReg;
    assign OutLast      = outLastReg;

endmodule

// File: tb/tb_sts_preamble_inserter.sv
// Self-checking bench for sts_preamble_inserter: one task per scenario,
// expected streams built from the STS table and payload lists.
module tb_sts_preamble_inserter;

    localparam int REPS = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, pEn, pLast, outReady;
    logic [15:0] pR, pI;
    logic        busy, pReady, oEn, oLast;
    logic [15:0] oR, oI;

    logic        rst1, start1, pEn1, pLast1, outReady1;
    logic [15:0] pR1, pI1;
    logic        busy1, pReady1, oEn1, oLast1;
    logic [15:0] oR1, oI1;

    int checks = 0;
    int passed = 0;

    logic [15:0] stsR [16] = '{
        16'h02F1, 16'hF78E, 16'hFF2C, 16'h0926, 16'h05E3, 16'h0926, 16'hFF2C, 16'hF78E,
        16'h02F1, 16'h0020, 16'hFAF2, 16'hFF2C, 16'h0000, 16'hFF2C, 16'hFAF2, 16'h0020};
    logic [15:0] stsI [16] = '{
        16'h02F1, 16'h0020, 16'hFAF2, 16'hFF2C, 16'h0000, 16'hFF2C, 16'hFAF2, 16'h0020,
        16'h02F1, 16'hF78E, 16'hFF2C, 16'h0926, 16'h05E3, 16'h0926, 16'hFF2C, 16'hF78E};

    sts_preamble_inserter #(.STS_REPS(REPS)) dut (
        .Clk(clk), .Rst(rst), .Start(start), .Busy(busy),
        .PayloadEnable(pEn), .PayloadDataR(pR), .PayloadDataI(pI), .PayloadLast(pLast),
        .PayloadReady(pReady), .OutEnable(oEn), .OutDataR(oR), .OutDataI(oI),
        .OutLast(oLast), .OutReady(outReady)
    );

    sts_preamble_inserter #(.STS_REPS(1)) dut1 (
        .Clk(clk), .Rst(rst1), .Start(start1), .Busy(busy1),
        .PayloadEnable(pEn1), .PayloadDataR(pR1), .PayloadDataI(pI1), .PayloadLast(pLast1),
        .PayloadReady(pReady1), .OutEnable(oEn1), .OutDataR(oR1), .OutDataI(oI1),
        .OutLast(oLast1), .OutReady(outReady1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; start = 0; pEn = 0; pLast = 0; pR = 0; pI = 0; outReady = 1;
        tick(); tick(); #1;
        checks++;
        if ({busy, pReady, oEn, oLast, oR, oI} !== 36'h0)
            $display("FAIL reset_init: got %h required 0", {busy, pReady, oEn, oLast, oR, oI});
        else passed++;
        rst = 0;
        start = 1; tick(); start = 0;
        repeat (16 * 3 + 5) tick();
        #1;
        checks++;
        if ({busy, oEn} !== 2'b11) $display("FAIL reset_midframe_active: got %b required 11", {busy, oEn});
        else passed++;
        rst = 1; tick(); #1;
        checks++;
        if ({busy, pReady, oEn, oLast, oR, oI} !== 36'h0)
            $display("FAIL reset_abort1: got %h required 0", {busy, pReady, oEn, oLast, oR, oI});
        else passed++;
        tick(); #1;
        checks++;
        if ({busy, pReady, oEn, oLast, oR, oI} !== 36'h0)
            $display("FAIL reset_abort2: got %h required 0", {busy, pReady, oEn, oLast, oR, oI});
        else passed++;
        rst = 0;
        start = 1; tick(); start = 0; #1;
        checks++;
        if ({busy, oEn} !== 2'b10) $display("FAIL reset_restart_t1: got %b required 10", {busy, oEn});
        else passed++;
        tick(); #1;
        checks++;
        if ({oEn, oLast, oR, oI} !== {2'b10, 32'h02F1_02F1})
            $display("FAIL reset_restart_s0: got %h required %h", {oEn, oLast, oR, oI}, {2'b10, 32'h02F1_02F1});
        else passed++;
        tick(); #1;
        checks++;
        if ({oEn, oR, oI} !== {1'b1, 32'hF78E_0020})
            $display("FAIL reset_restart_s1: got %h required %h", {oEn, oR, oI}, {1'b1, 32'hF78E_0020});
        else passed++;
        rst = 1; tick(); rst = 0;
    endtask

    task automatic test_preamble();
        outReady = 1; pEn = 0; pLast = 0;
        for (int k = 0; k <= 168; k++) begin
            start = (k == 5);
            #1;
            begin
                logic expEn;
                logic expRdy;
                expEn  = (k >= 7) && (k <= 166);
                expRdy = (k >= 166);
                checks++;
                if (oEn !== expEn || pReady !== expRdy || oLast !== 1'b0 ||
                    (expEn && {oR, oI} !== {stsR[(k - 7) % 16], stsI[(k - 7) % 16]}))
                    $display("FAIL preamble_cycle%0d: got en=%b rdy=%b last=%b data=%h required en=%b rdy=%b data=%h",
                             k, oEn, pReady, oLast, {oR, oI}, expEn, expRdy,
                             expEn ? {stsR[(k - 7) % 16], stsI[(k - 7) % 16]} : 32'h0);
                else passed++;
            end
            if (k == 11) begin
                checks++;
                if ({oR, oI} !== 32'h05E3_0000) $display("FAIL preamble_sample4: got %h required 05e30000", {oR, oI});
                else passed++;
            end
            if (k == 166) begin
                checks++;
                if ({oR, oI} !== 32'h0020_F78E) $display("FAIL preamble_sample159: got %h required 0020f78e", {oR, oI});
                else passed++;
            end
            tick();
        end
        start = 0;
    endtask

    task automatic test_payload();
        logic [15:0] prv [3] = '{16'h1000, 16'h0001, 16'h8000};
        logic [15:0] piv [3] = '{16'hF000, 16'h7FFF, 16'h0000};
        for (int j = 0; j < 3; j++) begin
            pEn = 1; pR = prv[j]; pI = piv[j]; pLast = (j == 2);
            #1;
            checks++;
            if (pReady !== 1'b1) $display("FAIL payload_ready%0d: got %b required 1", j, pReady);
            else passed++;
            tick();
            pEn = 0; pLast = 0;
            #1;
            checks++;
            if ({busy, oEn, oLast, oR, oI} !== {2'b11, (j == 2), prv[j], piv[j]})
                $display("FAIL payload_out%0d: got %h required %h", j, {busy, oEn, oLast, oR, oI},
                         {2'b11, (j == 2), prv[j], piv[j]});
            else passed++;
        end
        checks++;
        if (pReady !== 1'b0) $display("FAIL payload_idle_ready: got %b required 0", pReady);
        else passed++;
        tick(); #1;
        checks++;
        if ({busy, oEn, pReady} !== 3'b000) $display("FAIL payload_busy_fall: got %b required 000", {busy, oEn, pReady});
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [32:0] expQ [$];
        logic [32:0] gotQ [$];
        logic [15:0] payR [5];
        logic [15:0] payI [5];
        int pIdx = 0;
        bit holding = 0;
        bit prevStall = 0;
        logic [33:0] prevOut = '0;
        for (int j = 0; j < 5; j++) begin
            payR[j] = 16'($urandom);
            payI[j] = 16'($urandom);
        end
        for (int r = 0; r < REPS; r++)
            for (int s = 0; s < 16; s++) expQ.push_back({1'b0, stsR[s], stsI[s]});
        for (int j = 0; j < 5; j++) expQ.push_back({(j == 4), payR[j], payI[j]});
        outReady = 1; start = 1; tick(); start = 0;
        for (int cyc = 0; cyc < 5000 && gotQ.size() < expQ.size(); cyc++) begin
            if (prevStall) begin
                checks++;
                if ({oEn, oLast, oR, oI} !== prevOut)
                    $display("FAIL bp_stall_hold: got %h required %h", {oEn, oLast, oR, oI}, prevOut);
                else passed++;
            end
            outReady = 1'($urandom_range(0, 1));
            if (pIdx < 5) begin
                pEn = holding ? 1'b1 : 1'($urandom_range(0, 1));
                pR = payR[pIdx]; pI = payI[pIdx]; pLast = (pIdx == 4);
            end else begin
                pEn = 0; pLast = 0;
            end
            #1;
            if (oEn && outReady) gotQ.push_back({oLast, oR, oI});
            if (oEn && !outReady) begin
                checks++;
                if (pReady !== 1'b0) $display("FAIL bp_stall_ready: got %b required 0", pReady);
                else passed++;
            end
            holding = pEn && !pReady;
            if (pEn && pReady) pIdx++;
            prevStall = oEn && !outReady;
            prevOut = {oEn, oLast, oR, oI};
            tick();
        end
        outReady = 1; pEn = 0; pLast = 0;
        checks++;
        if (gotQ.size() != expQ.size()) $display("FAIL bp_count: got %0d required %0d", gotQ.size(), expQ.size());
        else passed++;
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
            checks++;
            if (gotQ[i] !== expQ[i]) $display("FAIL bp_item%0d: got %h required %h", i, gotQ[i], expQ[i]);
            else passed++;
        end
        tick();
    endtask

    task automatic test_start_collision();
        outReady = 1; pEn = 0; pLast = 0;
        start = 1; tick(); start = 0;
        for (int k = 1; k <= 161; k++) begin
            start = (k == 20) || (k == 90);
            #1;
            checks++;
            if (oEn !== (k >= 2) || (k >= 2 && {oR, oI} !== {stsR[(k - 2) % 16], stsI[(k - 2) % 16]}))
                $display("FAIL coll_sts_cycle%0d: got en=%b data=%h required en=%b", k, oEn, {oR, oI}, (k >= 2));
            else passed++;
            tick();
        end
        start = 1; pEn = 1; pLast = 1; pR = 16'h1234; pI = 16'h5678;
        #1;
        checks++;
        if (pReady !== 1'b1) $display("FAIL coll_last_ready: got %b required 1", pReady);
        else passed++;
        tick();
        start = 0; pEn = 0; pLast = 0;
        #1;
        checks++;
        if ({oEn, oLast, oR, oI} !== {2'b11, 32'h1234_5678})
            $display("FAIL coll_last_out: got %h required %h", {oEn, oLast, oR, oI}, {2'b11, 32'h1234_5678});
        else passed++;
        tick(); #1;
        checks++;
        if ({busy, oEn} !== 2'b00) $display("FAIL coll_start_ignored: got %b required 00", {busy, oEn});
        else passed++;
        // Second frame: Start right after the last acceptance, with OutLast stalled.
        start = 1; tick(); start = 0;
        repeat (161) tick();
        pEn = 1; pLast = 1; pR = 16'hABCD; pI = 16'h0123;
        #1;
        checks++;
        if (pReady !== 1'b1) $display("FAIL coll2_last_ready: got %b required 1", pReady);
        else passed++;
        tick();
        pEn = 0; pLast = 0; outReady = 0; start = 1;
        #1;
        checks++;
        if ({oEn, oLast, oR, oI} !== {2'b11, 32'hABCD_0123})
            $display("FAIL coll2_last_out: got %h required %h", {oEn, oLast, oR, oI}, {2'b11, 32'hABCD_0123});
        else passed++;
        tick();
        start = 0;
        #1;
        checks++;
        if ({busy, oEn, oLast, oR, oI} !== {3'b111, 32'hABCD_0123})
            $display("FAIL coll2_held: got %h required %h", {busy, oEn, oLast, oR, oI}, {3'b111, 32'hABCD_0123});
        else passed++;
        outReady = 1;
        tick(); #1;
        checks++;
        if ({oEn, oLast, oR, oI} !== {2'b10, 32'h02F1_02F1})
            $display("FAIL coll2_new_frame: got %h required %h", {oEn, oLast, oR, oI}, {2'b10, 32'h02F1_02F1});
        else passed++;
        rst = 1; tick(); rst = 0;
    endtask

    task automatic test_reps1();
        outReady1 = 1; pEn1 = 0; pLast1 = 0; pR1 = 0; pI1 = 0; start1 = 0;
        tick(); tick();
        rst1 = 0;
        start1 = 1; tick(); start1 = 0;
        for (int k = 1; k <= 19; k++) begin
            #1;
            checks++;
            if (oEn1 !== (k >= 2 && k <= 17) || pReady1 !== (k >= 17) ||
                (k >= 2 && k <= 17 && {oR1, oI1} !== {stsR[k - 2], stsI[k - 2]}))
                $display("FAIL reps1_cycle%0d: got en=%b rdy=%b data=%h required en=%b rdy=%b",
                         k, oEn1, pReady1, {oR1, oI1}, (k >= 2 && k <= 17), (k >= 17));
            else passed++;
            tick();
        end
        pEn1 = 1; pLast1 = 1; pR1 = 16'h4000; pI1 = 16'hC000;
        tick();
        pEn1 = 0; pLast1 = 0;
        #1;
        checks++;
        if ({oEn1, oLast1, oR1, oI1} !== {2'b11, 32'h4000_C000})
            $display("FAIL reps1_payload: got %h required %h", {oEn1, oLast1, oR1, oI1}, {2'b11, 32'h4000_C000});
        else passed++;
        tick(); #1;
        checks++;
        if (busy1 !== 1'b0) $display("FAIL reps1_done: got %b required 0", busy1);
        else passed++;
    endtask

    initial begin
        rst1 = 1; start1 = 0; pEn1 = 0; pLast1 = 0; pR1 = 0; pI1 = 0; outReady1 = 1;
        test_reset();
        test_preamble();
        test_payload();
        test_backpressure();
        test_start_collision();
        test_reps1();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
